// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate extender with valid/ready handshake.
//
// An IN_W immediate, a 3-bit op code and a passthrough tag enter on
// in_valid & in_ready. The extended OUT_W result, the same tag and an
// illegal-op flag leave STAGES cycles later on out_valid & out_ready.
// Every stage advances whenever its successor can take its contents, so
// bubbles collapse and a full pipe still sustains one beat per cycle.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept this cycle (combinational from out_ready)
//   in_imm     raw immediate, IN_W bits
//   in_op      extension mode (0..6 legal, 7 illegal)
//   in_tag     opaque tag returned with the result
//   out_valid  result valid
//   out_ready  consumer accepts this cycle
//   out_imm    extended result, OUT_W bits
//   out_tag    tag belonging to out_imm
//   out_err    1 = illegal op, out_imm forced to 0
//   bad_cnt    saturating count of accepted illegal ops
//
// Parameter constraints: IN_W >= 8, OUT_W >= IN_W+2, STAGES in 1..4.

module ext_pipe #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int unsigned R    = OUT_W - IN_W;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage state, flattened for neighbour access.
    logic [STAGES-1:0] stg_v;
    logic [OUT_W-1:0]  stg_d [STAGES];
    logic [TAG_W-1:0]  stg_t [STAGES];
    logic [STAGES-1:0] stg_e;

    // load[k]: stage k captures its predecessor at the next edge.
    logic [STAGES-1:0] load;
    logic              accept;

    // Extension datapath ahead of stage 0.
    logic [OUT_W-1:0]  zext;
    logic [OUT_W-1:0]  sext;
    logic [OUT_W-1:0]  ext_imm;
    logic              ext_err;

    // Readiness ripples backwards from the consumer: a stage may load when it
    // is empty or when whatever sits downstream is taking its contents.
    always_comb begin : p_load
        logic take;
        take = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            load[k] = ~stg_v[k] | take;
            take    = load[k];
        end
    end

    assign in_ready = ~reset & load[0];
    assign accept   = in_valid & in_ready;

    assign zext = {{R{1'b0}}, in_imm};
    assign sext = {{R{in_imm[IN_W-1]}}, in_imm};

    // Op decode; op 7 yields zero with the error flag.
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        case (in_op)
            3'd0: ext_imm = zext;
            3'd1: ext_imm = sext;
            3'd2: ext_imm = {in_imm, {R{1'b0}}};
            3'd3: ext_imm = {sext[OUT_W-3:0], 2'b00};
            3'd4: ext_imm = {zext[OUT_W-3:0], 2'b00};
            3'd5: ext_imm = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
            3'd6: ext_imm = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
            default: begin
                ext_imm = '0;
                ext_err = 1'b1;
            end
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_v;
        logic [OUT_W-1:0] src_d;
        logic [TAG_W-1:0] src_t;
        logic             src_e;
        logic             v_q;
        logic [OUT_W-1:0] d_q;
        logic [TAG_W-1:0] t_q;
        logic             e_q;

        if (k == 0) begin : g_head
            assign src_v = accept;
            assign src_d = ext_imm;
            assign src_t = in_tag;
            assign src_e = ext_err;
        end else begin : g_body
            assign src_v = stg_v[k-1];
            assign src_d = stg_d[k-1];
            assign src_t = stg_t[k-1];
            assign src_e = stg_e[k-1];
        end

        // Payload only updates with a valid source so idle inputs never leak
        // into the held output registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
                d_q <= '0;
                t_q <= '0;
                e_q <= 1'b0;
            end else if (load[k]) begin
                v_q <= src_v;
                if (src_v) begin
                    d_q <= src_d;
                    t_q <= src_t;
                    e_q <= src_e;
                end
            end
        end

        assign stg_v[k] = v_q;
        assign stg_d[k] = d_q;
        assign stg_t[k] = t_q;
        assign stg_e[k] = e_q;
    end

    assign out_valid = stg_v[LAST];
    assign out_imm   = stg_d[LAST];
    assign out_tag   = stg_t[LAST];
    assign out_err   = stg_e[LAST];

    // Saturating count of accepted illegal ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_cnt <= '0;
        end else if (accept && ext_err && (bad_cnt != {CNT_W{1'b1}})) begin
            bad_cnt <= bad_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: three instances (STAGES=1 with a 2-bit counter,
// STAGES=2, STAGES=3) exercised by one task per scenario.

module tb_ext_pipe;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // u1: STAGES=1, CNT_W=2
    logic        u1_valid, u1_ready, u1_oready, u1_ovalid, u1_oerr;
    logic [15:0] u1_imm;
    logic [2:0]  u1_op;
    logic [4:0]  u1_tag, u1_otag;
    logic [31:0] u1_oimm;
    logic [1:0]  u1_cnt;
    // u2: STAGES=2
    logic        u2_valid, u2_ready, u2_oready, u2_ovalid, u2_oerr;
    logic [15:0] u2_imm;
    logic [2:0]  u2_op;
    logic [4:0]  u2_tag, u2_otag;
    logic [31:0] u2_oimm;
    logic [7:0]  u2_cnt;
    // u3: STAGES=3
    logic        u3_valid, u3_ready, u3_oready, u3_ovalid, u3_oerr;
    logic [15:0] u3_imm;
    logic [2:0]  u3_op;
    logic [4:0]  u3_tag, u3_otag;
    logic [31:0] u3_oimm;
    logic [7:0]  u3_cnt;

    ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1), .TAG_W(5), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .in_valid(u1_valid), .in_ready(u1_ready),
        .in_imm(u1_imm), .in_op(u1_op), .in_tag(u1_tag), .out_valid(u1_ovalid),
        .out_ready(u1_oready), .out_imm(u1_oimm), .out_tag(u1_otag),
        .out_err(u1_oerr), .bad_cnt(u1_cnt));

    ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2), .TAG_W(5), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset), .in_valid(u2_valid), .in_ready(u2_ready),
        .in_imm(u2_imm), .in_op(u2_op), .in_tag(u2_tag), .out_valid(u2_ovalid),
        .out_ready(u2_oready), .out_imm(u2_oimm), .out_tag(u2_otag),
        .out_err(u2_oerr), .bad_cnt(u2_cnt));

    ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(3), .TAG_W(5), .CNT_W(8)) u3 (
        .clk(clk), .reset(reset), .in_valid(u3_valid), .in_ready(u3_ready),
        .in_imm(u3_imm), .in_op(u3_op), .in_tag(u3_tag), .out_valid(u3_ovalid),
        .out_ready(u3_oready), .out_imm(u3_oimm), .out_tag(u3_otag),
        .out_err(u3_oerr), .bad_cnt(u3_cnt));

    // Reference extender: returns {err, value}.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [15:0] imm);
        logic signed [31:0] s16;
        logic signed [31:0] s8;
        logic [31:0]        z16;
        s16 = 32'($signed(imm));
        s8  = 32'($signed(imm[7:0]));
        z16 = 32'(imm);
        case (op)
            3'd0: model = {1'b0, z16};
            3'd1: model = {1'b0, s16};
            3'd2: model = {1'b0, imm, 16'h0000};
            3'd3: model = {1'b0, 32'(s16 << 2)};
            3'd4: model = {1'b0, 32'(z16 << 2)};
            3'd5: model = {1'b0, s8};
            3'd6: model = {1'b0, 32'(imm[7:0])};
            default: model = {1'b1, 32'h0};
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        u1_valid = 0; u2_valid = 0; u3_valid = 0;
        u1_oready = 0; u2_oready = 0; u3_oready = 0;
        u1_imm = 0; u2_imm = 0; u3_imm = 0;
        u1_op = 0; u2_op = 0; u3_op = 0;
        u1_tag = 0; u2_tag = 0; u3_tag = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({u1_ovalid, u2_ovalid, u3_ovalid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_out_valid got=%b want=000", {u1_ovalid, u2_ovalid, u3_ovalid});
        end
        checks++;
        if ({u1_ready, u2_ready, u3_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=000", {u1_ready, u2_ready, u3_ready});
        end
        checks++;
        if (u1_cnt !== 2'd0 || u2_cnt !== 8'd0 || u3_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_bad_cnt got=%0d/%0d/%0d want=0", u1_cnt, u2_cnt, u3_cnt);
        end
        checks++;
        if (u1_oimm !== 32'h0 || u1_otag !== 5'd0 || u1_oerr !== 1'b0) begin
            failures++;
            $display("FAIL reset_payload got=%h/%0d/%b want=0", u1_oimm, u1_otag, u1_oerr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({u1_ready, u2_ready, u3_ready} !== 3'b111) begin
            failures++;
            $display("FAIL post_reset_in_ready got=%b want=111", {u1_ready, u2_ready, u3_ready});
        end
    endtask

    task automatic test_ops;
        logic [2:0]  op_t  [11];
        logic [15:0] imm_t [11];
        logic [31:0] exp_t [11];
        op_t  = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd5, 3'd6, 3'd4, 3'd4, 3'd3, 3'd3, 3'd5};
        imm_t = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h0080, 16'h0080,
                  16'h4001, 16'h8001, 16'h4000, 16'h8000, 16'h127F};
        exp_t = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC,
                  32'hFFFFFF80, 32'h00000080, 32'h00010004, 32'h00020004,
                  32'h00010000, 32'hFFFE0000, 32'h0000007F};
        u1_oready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            u1_valid = 1'b1;
            u1_op    = op_t[i];
            u1_imm   = imm_t[i];
            u1_tag   = 5'(i + 7);
            @(negedge clk);
            u1_valid = 1'b0;
            u1_op    = 3'd7;
            checks++;
            if (u1_ovalid !== 1'b1 || u1_oimm !== exp_t[i] || u1_oerr !== 1'b0 ||
                u1_otag !== 5'(i + 7)) begin
                failures++;
                $display("FAIL op%0d_imm%h got v=%b imm=%h err=%b tag=%0d want v=1 imm=%h err=0 tag=%0d",
                         op_t[i], imm_t[i], u1_ovalid, u1_oimm, u1_oerr, u1_otag, exp_t[i], i + 7);
            end
        end
        @(negedge clk);
        checks++;
        if (u1_ovalid !== 1'b0) begin
            failures++;
            $display("FAIL ops_drained got=%b want=0", u1_ovalid);
        end
    endtask

    task automatic test_illegal;
        int exp_cnt;
        u1_oready = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            u1_valid = 1'b1;
            u1_op    = 3'd7;
            u1_imm   = 16'hBEEF;
            u1_tag   = 5'd3;
            @(negedge clk);
            u1_valid = 1'b0;
            exp_cnt  = (n > 3) ? 3 : n;
            if (n == 1) begin
                checks++;
                if (u1_ovalid !== 1'b1 || u1_oimm !== 32'h0 || u1_oerr !== 1'b1 ||
                    u1_otag !== 5'd3) begin
                    failures++;
                    $display("FAIL illegal_beat got v=%b imm=%h err=%b tag=%0d want v=1 imm=0 err=1 tag=3",
                             u1_ovalid, u1_oimm, u1_oerr, u1_otag);
                end
            end
            checks++;
            if (u1_cnt !== 2'(exp_cnt)) begin
                failures++;
                $display("FAIL bad_cnt_after_%0d got=%0d want=%0d", n, u1_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got  = 0;
        bit started = 0;
        u2_oready = 1'b0;
        u2_op     = 3'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            u2_valid = (sent < 4);
            u2_tag   = 5'(sent);
            u2_imm   = 16'(sent);
            #1;
            if (u2_valid && u2_ready) sent++;
        end
        checks++;
        if (sent !== 2 || u2_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_capacity got accepted=%0d in_ready=%b want accepted=2 in_ready=0",
                     sent, u2_ready);
        end
        checks++;
        if (u2_ovalid !== 1'b1 || u2_otag !== 5'd0) begin
            failures++;
            $display("FAIL bp_held_head got v=%b tag=%0d want v=1 tag=0", u2_ovalid, u2_otag);
        end
        u2_oready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (u2_ovalid) begin
                started = 1;
                checks++;
                if (u2_otag !== 5'(got) || u2_oimm !== 32'(got)) begin
                    failures++;
                    $display("FAIL bp_order_%0d got tag=%0d imm=%h want tag=%0d imm=%h",
                             got, u2_otag, u2_oimm, got, got);
                end
                got++;
            end else if (started) begin
                checks++;
                failures++;
                $display("FAIL bp_gap got out_valid=0 want 1 after %0d results", got);
            end
            u2_valid = (sent < 4);
            u2_tag   = 5'(sent);
            u2_imm   = 16'(sent);
            #1;
            if (u2_valid && u2_ready) sent++;
        end
        u2_valid = 1'b0;
        checks++;
        if (got !== 4) begin
            failures++;
            $display("FAIL bp_count got=%0d want=4", got);
        end
    endtask

    task automatic test_stream;
        logic [32:0] exp_r [100];
        logic [4:0]  exp_g [100];
        logic [32:0] m;
        int sent  = 0;
        int got   = 0;
        int first = -1;
        u3_oready = 1'b1;
        for (int c = 0; c < 130 && got < 100; c++) begin
            @(negedge clk);
            if (u3_ovalid) begin
                if (first < 0) first = c;
                if (got < 100) begin
                    checks++;
                    if ({u3_oerr, u3_oimm} !== exp_r[got] || u3_otag !== exp_g[got]) begin
                        failures++;
                        $display("FAIL stream_%0d got err=%b imm=%h tag=%0d want err=%b imm=%h tag=%0d",
                                 got, u3_oerr, u3_oimm, u3_otag, exp_r[got][32],
                                 exp_r[got][31:0], exp_g[got]);
                    end
                end
                got++;
            end else if (first >= 0) begin
                checks++;
                failures++;
                $display("FAIL stream_gap got out_valid=0 want 1 at result %0d", got);
            end
            if (sent < 100) begin
                u3_valid = 1'b1;
                u3_op    = (sent < 8) ? 3'(sent) : 3'($urandom_range(0, 7));
                u3_imm   = 16'($urandom);
                u3_tag   = 5'(sent);
                #1;
                if (u3_ready) begin
                    m            = model(u3_op, u3_imm);
                    exp_r[sent]  = m;
                    exp_g[sent]  = 5'(sent);
                    sent++;
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL stream_in_ready got=0 want=1 at beat %0d", sent);
                end
            end else begin
                u3_valid = 1'b0;
            end
        end
        u3_valid = 1'b0;
        checks++;
        if (first !== 3) begin
            failures++;
            $display("FAIL stream_latency got first=%0d want=3", first);
        end
        checks++;
        if (got !== 100) begin
            failures++;
            $display("FAIL stream_count got=%0d want=100", got);
        end
    endtask

    task automatic test_reset_flight;
        int sent = 0;
        u2_oready = 1'b0;
        u2_op     = 3'd7;
        for (int c = 0; c < 10 && sent < 2; c++) begin
            @(negedge clk);
            u2_valid = 1'b1;
            u2_tag   = 5'(20 + sent);
            u2_imm   = 16'h1111;
            #1;
            if (u2_ready) sent++;
        end
        @(negedge clk);
        u2_valid = 1'b0;
        checks++;
        if (u2_ovalid !== 1'b1 || u2_cnt !== 8'd2) begin
            failures++;
            $display("FAIL flight_setup got v=%b cnt=%0d want v=1 cnt=2", u2_ovalid, u2_cnt);
        end
        reset    = 1'b1;
        u2_valid = 1'b1;
        u2_op    = 3'd7;
        u2_tag   = 5'd9;
        #1;
        checks++;
        if (u2_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_busy got=%b want=0", u2_ready);
        end
        @(negedge clk);
        checks++;
        if (u2_ovalid !== 1'b0 || u2_cnt !== 8'd0 || u2_otag !== 5'd0 || u2_oerr !== 1'b0) begin
            failures++;
            $display("FAIL reset_flush got v=%b cnt=%0d tag=%0d err=%b want 0/0/0/0",
                     u2_ovalid, u2_cnt, u2_otag, u2_oerr);
        end
        reset     = 1'b0;
        u2_valid  = 1'b0;
        u2_oready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (u2_ovalid !== 1'b0 || u2_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_beat_dropped got v=%b cnt=%0d want v=0 cnt=0", u2_ovalid, u2_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_ops;
        test_illegal;
        test_backpressure;
        test_stream;
        test_reset_flight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
